// File: rtl/prbs6_checker_if.sv
// Serial PRBS6 checker bus: input bit stream, lock/error status and debug state.
// Handshake: din is consumed on a rising clk only when din_valid=1; there is no
// ready, the checker always accepts. Status outputs are registered by the checker.
interface prbs6_checker_if;
    logic        din;
    logic        din_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err, err_cnt, state
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err, err_cnt, state
    );
endinterface

// File: rtl/prbs6_checker.sv
// PRBS6 (x^6+x^5+1, XNOR) checker with SEARCH/VERIFY/LOCKED acquisition and flywheel.
// Optional feature macro: PRBS6_CHECKER_ERRCNT_EN enables the saturating err_cnt and clr_cnt.
module prbs6_checker #(
    parameter int LOCK_CNT  = 12,
    parameter int ERR_LIMIT = 8,
    parameter int WIN_LEN   = 64
) (
    input logic            clk,
    input logic            reset,
    prbs6_checker_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);

    state_t          state;
    logic [6:1]      sr;
    logic [2:0]      fill_cnt;
    logic [MW-1:0]   match_cnt;
    logic [WW-1:0]   win_cnt;
    logic [EW-1:0]   win_err;
    logic            locked_q;
    logic            err_q;

    logic            pred;
    logic            mismatch;
    logic [6:1]      sr_din;
    logic            err_hit;

    assign pred     = sr[5] ~^ sr[6];
    assign mismatch = bus.din ^ pred;
    assign sr_din   = {sr[5:1], bus.din};
    assign err_hit  = bus.din_valid && (state == LOCKED) && mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    SEARCH: begin
                        sr <= sr_din;
                        if (fill_cnt == 3'd5) begin
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    VERIFY: begin
                        sr <= sr_din;
                        if (mismatch) begin
                            state     <= SEARCH;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            match_cnt <= '0;
                            // All-ones is the XNOR lockup state: it predicts itself forever.
                            if (sr_din == 6'b111111) begin
                                state    <= SEARCH;
                                fill_cnt <= '0;
                            end else begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                win_cnt  <= '0;
                                win_err  <= '0;
                            end
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end
                    LOCKED: begin
                        // Flywheel: regenerate from our own prediction, never from din.
                        sr    <= {sr[5:1], pred};
                        err_q <= mismatch;
                        if (mismatch && (win_err == ERR_LAST)) begin
                            state     <= SEARCH;
                            locked_q  <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err + EW'(mismatch);
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                        fill_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked = locked_q;
    assign bus.err    = err_q;
    assign bus.state  = state;

`ifdef PRBS6_CHECKER_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            err_cnt_q <= '0;
        end else if (err_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    logic unused_errcnt_inputs;

    assign unused_errcnt_inputs = bus.clr_cnt ^ err_hit;
    assign bus.err_cnt = '0;
`endif

    a_locked_matches_state: assert property (
        @(posedge clk) disable iff (reset) bus.locked == (state == LOCKED)
    );

endmodule

// File: tb/tb_prbs6_checker.sv
// Self-checking bench for prbs6_checker: scenario table plus hand-written corner sequences.
// Honours PRBS6_CHECKER_ERRCNT_EN: err_cnt expectations collapse to 0 when it is undefined.
module tb_prbs6_checker;

    localparam int LOCK_CNT  = 12;
    localparam int ERR_LIMIT = 8;
    localparam int WIN_LEN   = 64;
    localparam int W         = 18;

`ifdef PRBS6_CHECKER_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    prbs6_checker_if bus();

    prbs6_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    n_cycles;
        bit    toggle;
        bit    hold_one;
        int    inj_start;
        int    inj_count;
        int    inj_step;
        int    clr_bit;
        int    rst_cyc;
        bit    exp_locked;
        int    exp_errcnt;
        int    exp_pulses;
    } scen_t;

    scen_t        tbl[9];
    logic [W-1:0] exp_q[$];
    logic [6:1]   lfsr;

    int n_vec    = 0;
    int n_miss   = 0;
    int m_pulses = 0;
    bit m_lk;
    bit m_no_lock;
    int m_acq;
    int m_wpos;
    int m_werr;
    int m_errcnt;

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d, expected locked=%0b err=%0b err_cnt=%0d",
                     name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic lfsr_advance();
        lfsr = {lfsr[5:1], lfsr[5] ~^ lfsr[6]};
    endtask

    // d is the driven bit, t the true stream bit; their difference is an injected error.
    task automatic step(input bit v, input bit d, input bit t, input bit clr, input bit rst,
                        input string tag);
        logic         e_err;
        logic [W-1:0] e;
        logic [W-1:0] got;
        e_err = 1'b0;
        if (rst) begin
            m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0; m_errcnt = 0;
        end else begin
            if (v) begin
                if (m_lk) begin
                    m_wpos++;
                    if (d != t) begin
                        e_err = 1'b1;
                        m_werr++;
                        if (m_errcnt < 65535) m_errcnt++;
                    end
                    if (m_werr == ERR_LIMIT) begin
                        m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0;
                    end else if (m_wpos == WIN_LEN) begin
                        m_wpos = 0; m_werr = 0;
                    end
                end else begin
                    m_acq++;
                    if (m_acq == 6 + LOCK_CNT && !m_no_lock) begin
                        m_lk = 1; m_wpos = 0; m_werr = 0;
                    end
                end
            end
            if (clr) m_errcnt = 0;
        end
        e = {m_lk, e_err, ERRCNT_ON ? 16'(m_errcnt) : 16'd0};
        exp_q.push_back(e);
        reset         = rst;
        bus.din_valid = v;
        bus.din       = d;
        bus.clr_cnt   = clr;
        @(posedge clk);
        #1;
        got = {bus.locked, bus.err, bus.err_cnt};
        m_pulses += int'(bus.err);
        check_vec(tag, got, exp_q.pop_front());
        reset = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        reset         = 1'b1;
        bus.din_valid = 1'b1;
        bus.clr_cnt   = 1'b1;
        bus.din       = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #1;
        check_int({tag, "_reset_state"}, int'({bus.state, bus.locked, bus.err, bus.err_cnt}), 0);
        reset         = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        m_lk = 0; m_acq = 0; m_wpos = 0; m_werr = 0; m_errcnt = 0; m_no_lock = 0;
        lfsr = '0;
    endtask

    task automatic good_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, lfsr[6], lfsr[6], 1'b0, 1'b0, tag);
            lfsr_advance();
        end
    endtask

    task automatic run_scen(input scen_t s);
        int vb;
        int p0;
        int k;
        bit v;
        bit inj;
        bit t;
        bit d;
        apply_reset(s.name);
        m_no_lock = s.hold_one;
        p0 = m_pulses;
        vb = 0;
        for (int c = 0; c < s.n_cycles; c++) begin
            v = s.toggle ? (c % 2 == 0) : 1'b1;
            if (c == s.rst_cyc) begin
                step(1'b1, lfsr[6], lfsr[6], 1'b0, 1'b1, $sformatf("%s#%0d", s.name, c));
            end else if (v) begin
                vb++;
                k   = vb - s.inj_start;
                inj = (s.inj_count > 0) && (k >= 0) && (k % s.inj_step == 0) &&
                      (k / s.inj_step < s.inj_count);
                t   = s.hold_one ? 1'b1 : lfsr[6];
                d   = t ^ inj;
                step(1'b1, d, t, (vb == s.clr_bit), 1'b0, $sformatf("%s#%0d", s.name, c));
                lfsr_advance();
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                     $sformatf("%s#%0d", s.name, c));
            end
        end
        check_int({s.name, "_final_locked"}, int'(bus.locked), int'(s.exp_locked));
        check_int({s.name, "_final_err_cnt"}, int'(bus.err_cnt), ERRCNT_ON ? s.exp_errcnt : 0);
        check_int({s.name, "_err_pulses"}, m_pulses - p0, s.exp_pulses);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        //         name        cyc  tgl one  inj cnt stp clr rst  lk cnt pulses
        tbl[0] = '{"clean",    1000, 0, 0,   0,  0,  1,  0, -1,  1, 0, 0};
        tbl[1] = '{"single",    200, 0, 0, 100,  1,  1,  0, -1,  1, 1, 1};
        tbl[2] = '{"burst8",    200, 0, 0, 100,  8,  3,  0, -1,  1, 8, 8};
        tbl[3] = '{"stuck1",    300, 0, 1,   0,  0,  1,  0, -1,  0, 0, 0};
        tbl[4] = '{"toggle",    200, 1, 0,  60,  1,  1,  0, -1,  1, 1, 1};
        tbl[5] = '{"clr_same",  200, 0, 0, 100,  6, 10, 150, -1, 1, 0, 6};
        tbl[6] = '{"rst_lock",  200, 0, 0,   0,  0,  1,  0, 99,  1, 0, 0};
        tbl[7] = '{"win_split", 300, 0, 0, 140,  8,  1,  0, -1,  1, 8, 8};
        tbl[8] = '{"win_last",  300, 0, 0, 139,  8,  1,  0, -1,  1, 8, 8};

        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        lfsr          = '0;

        for (int i = 0; i < 9; i++) run_scen(tbl[i]);

        // Exact acquisition timing: VERIFY after 6 bits, LOCKED after 18.
        apply_reset("edge");
        good_bits(6, "edge_fill");
        check_int("edge_verify_state", int'(bus.state), 1);
        good_bits(11, "edge_verify");
        check_int("edge_pre_lock", int'(bus.locked), 0);
        good_bits(1, "edge_lock");
        check_int("edge_at_lock", int'(bus.locked), 1);
        check_int("edge_locked_state", int'(bus.state), 2);

        // Idle cycles with garbage din hold the lock; then one error and a stand-alone clear.
        apply_reset("idle");
        good_bits(30, "idle_acq");
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, "idle_hold");
        check_int("idle_state_held", int'(bus.state), 2);
        p0 = m_pulses;
        step(1'b1, ~lfsr[6], lfsr[6], 1'b0, 1'b0, "idle_inj");
        lfsr_advance();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle_clr");
        good_bits(10, "idle_tail");
        check_int("idle_pulses", m_pulses - p0, 1);
        check_int("idle_cnt_cleared", int'(bus.err_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
